send_unit: RTL and testbench

- Executes the SEND instruction (SEND addr(a), size(b), port(im)) once the decoder asserts its send strobe.
- Streams `size` consecutive data-memory words, starting at `addr`, onto the inter-PU network port selected by the 4-bit immediate, using a valid/ready handshake.
- Sits downstream of the decoder and the register file, beside the data memory.
- Holds the PU stalled through `busy` until the transfer completes.

---
 rtl/send_unit_pkg.sv | 14 +
 rtl/send_unit.sv | 98 +++++++++
 tb/tb_send_unit.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/send_unit_pkg.sv
// Shared types for the SEND instruction unit: FSM state encodings and default port-id width.
package send_unit_pkg;

  localparam int unsigned PortW = 4;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRd   = 3'd1,
    StLat  = 3'd2,
    StXmit = 3'd3,
    StFin  = 3'd4
  } send_state_e;

endpackage

// File: rtl/send_unit.sv
// SEND instruction engine: streams `size` data-memory words from `addr` onto a network port
// with a valid/ready handshake, stalling the PU through `busy` until the transfer completes.
module send_unit
  import send_unit_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8,
  parameter int unsigned PW = PortW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          send,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] size,
  input  logic [PW-1:0] port,
  output logic          busy,
  output logic          done,
  output logic          dm_re,
  output logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_rdata,
  output logic          tx_valid,
  output logic [DW-1:0] tx_data,
  output logic [PW-1:0] tx_port,
  output logic          tx_last,
  input  logic          tx_ready
);

  send_state_e   state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [DW-1:0] remaining_q, remaining_d;
  logic [PW-1:0] tx_port_q, tx_port_d;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic          tx_last_q, tx_last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      tx_port_q   <= '0;
      tx_data_q   <= '0;
      tx_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      tx_port_q   <= tx_port_d;
      tx_data_q   <= tx_data_d;
      tx_last_q   <= tx_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    tx_port_d   = tx_port_q;
    tx_data_d   = tx_data_q;
    tx_last_d   = tx_last_q;
    unique case (state_q)
      StIdle: begin
        if (send) begin
          cur_addr_d  = addr[AW-1:0];
          remaining_d = size;
          tx_port_d   = port;
          state_d     = (size != '0) ? StRd : StFin;
        end
      end
      StRd: state_d = StLat;
      StLat: begin
        // Read data arrives one cycle after dm_re, i.e. during this state.
        tx_data_d = dm_rdata;
        tx_last_d = (remaining_q == DW'(1));
        state_d   = StXmit;
      end
      StXmit: begin
        if (tx_ready) begin
          remaining_d = remaining_q - DW'(1);
          cur_addr_d  = cur_addr_q + AW'(1);
          state_d     = tx_last_q ? StFin : StRd;
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // busy is combinational on send so the PC holds on the SEND instruction in its decode cycle.
  assign busy     = (state_q != StIdle) | send;
  assign done     = (state_q == StFin);
  assign dm_re    = (state_q == StRd);
  assign dm_addr  = (state_q == StRd) ? cur_addr_q : '0;
  assign tx_valid = (state_q == StXmit);
  assign tx_data  = tx_data_q;
  assign tx_port  = tx_port_q;
  assign tx_last  = tx_last_q;

endmodule

// File: tb/tb_send_unit.sv
// Self-checking bench for send_unit: table-driven transfers plus stall, double-send and
// mid-transfer reset sequences, with a scoreboard queue of expected network words.
module tb_send_unit;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          send;
  logic [DW-1:0] addr;
  logic [DW-1:0] size;
  logic [PW-1:0] port;
  logic          busy;
  logic          done;
  logic          dm_re;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_rdata = '0;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic [PW-1:0] tx_port;
  logic          tx_last;
  logic          tx_ready;

  always #5 clk = ~clk;

  send_unit #(.DW(DW), .AW(AW), .PW(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .send     (send),
    .addr     (addr),
    .size     (size),
    .port     (port),
    .busy     (busy),
    .done     (done),
    .dm_re    (dm_re),
    .dm_addr  (dm_addr),
    .dm_rdata (dm_rdata),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_port  (tx_port),
    .tx_last  (tx_last),
    .tx_ready (tx_ready)
  );

  logic [DW-1:0] mem [256];

  always @(posedge clk) begin
    if (dm_re) dm_rdata <= mem[dm_addr];
  end

  typedef struct {
    logic [DW-1:0] data;
    logic [PW-1:0] port;
    logic          last;
  } word_t;

  typedef struct {
    logic [DW-1:0] addr;
    logic [DW-1:0] size;
    logic [PW-1:0] port;
    int            lat;
  } vec_t;

  word_t exp_q[$];
  vec_t  vecs[5];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int send_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int busy_cnt = 0;
  int rd_cnt = 0;
  int hs_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    word_t w;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
    if (dm_re) rd_cnt++;
    if (tx_valid && tx_ready && !rst) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word", tx_data);
      end else begin
        w = exp_q.pop_front();
        chk("tx_data", 32'(tx_data), 32'(w.data));
        chk("tx_port", 32'(tx_port), 32'(w.port));
        chk("tx_last", 32'(tx_last), 32'(w.last));
      end
    end
  end

  // Drives a one-cycle send strobe; optionally queues the words the transfer must produce.
  task automatic do_send(input logic [DW-1:0] a, input logic [DW-1:0] s, input logic [PW-1:0] p,
                         input bit push);
    word_t      w;
    logic [7:0] ad;
    if (push) begin
      for (int i = 0; i < int'(s); i++) begin
        ad     = a[7:0] + 8'(i);
        w.data = mem[ad];
        w.port = p;
        w.last = (i == int'(s) - 1);
        exp_q.push_back(w);
      end
    end
    send     = 1'b1;
    addr     = a;
    size     = s;
    port     = p;
    send_cyc = cyc;
    #1;
    chk("busy_on_send", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    send = 1'b0;
  endtask

  task automatic wait_done(input int base, input int bound);
    int n = 0;
    while (done_cnt == base && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == base) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected a done pulse", bound);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_done, b_busy, b_rd, b_hs, n, s0;

    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 37) ^ 16'h5a00;
    mem[8'h10] = 16'hAAAA;
    mem[8'h11] = 16'hBBBB;
    mem[8'h12] = 16'hCCCC;
    mem[8'hFF] = 16'h1234;
    mem[8'h00] = 16'h5678;
    mem[8'h40] = 16'hBEEF;

    // Latency = send cycle to done cycle: 3 cycles per word plus FIN, or straight to FIN.
    vecs[0] = '{addr: 16'h0010, size: 16'd3,   port: 4'd5,  lat: 10};
    vecs[1] = '{addr: 16'h0000, size: 16'd0,   port: 4'd2,  lat: 1};
    vecs[2] = '{addr: 16'h00FF, size: 16'd2,   port: 4'd9,  lat: 7};
    vecs[3] = '{addr: 16'h1234, size: 16'd1,   port: 4'd15, lat: 4};
    vecs[4] = '{addr: 16'h00F0, size: 16'd260, port: 4'd3,  lat: 781};

    rst      = 1'b1;
    send     = 1'b0;
    addr     = '0;
    size     = '0;
    port     = '0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_dm_re",    32'(dm_re),    32'd0);
    chk("rst_dm_addr",  32'(dm_addr),  32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'd0);
    chk("rst_tx_port",  32'(tx_port),  32'd0);
    chk("rst_tx_last",  32'(tx_last),  32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) begin
      b_done   = done_cnt;
      b_busy   = busy_cnt;
      b_rd     = rd_cnt;
      b_hs     = hs_cnt;
      tx_ready = 1'b1;
      do_send(vecs[v].addr, vecs[v].size, vecs[v].port, 1'b1);
      wait_done(b_done, vecs[v].lat + 20);
      repeat (3) @(posedge clk);
      #1;
      chk("latency",     32'(done_cyc - send_cyc), 32'(vecs[v].lat));
      chk("done_count",  32'(done_cnt - b_done),   32'd1);
      chk("busy_cycles", 32'(busy_cnt - b_busy),   32'(vecs[v].lat + 1));
      chk("mem_reads",   32'(rd_cnt - b_rd),       32'(vecs[v].size));
      chk("handshakes",  32'(hs_cnt - b_hs),       32'(vecs[v].size));
      chk("queue_empty", 32'(exp_q.size()),        32'd0);
      chk("busy_idle",   32'(busy),                32'd0);
    end

    // Network stall: outputs must hold while tx_ready is low.
    b_done   = done_cnt;
    b_hs     = hs_cnt;
    tx_ready = 1'b0;
    do_send(16'h0040, 16'd1, 4'd3, 1'b1);
    n = 0;
    while (!tx_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(tx_valid), 32'd1);
      chk("stall_data",  32'(tx_data),  32'hBEEF);
      chk("stall_last",  32'(tx_last),  32'd1);
      chk("stall_port",  32'(tx_port),  32'd3);
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    wait_done(b_done, 20);
    repeat (2) @(posedge clk);
    #1;
    chk("stall_handshakes", 32'(hs_cnt - b_hs),   32'd1);
    chk("stall_done_count", 32'(done_cnt - b_done), 32'd1);

    // A second send mid-transfer must not disturb the latched parameters.
    b_done = done_cnt;
    b_hs   = hs_cnt;
    do_send(16'h0020, 16'd4, 4'd1, 1'b1);
    s0 = send_cyc;
    repeat (4) @(posedge clk);
    #1;
    send = 1'b1;
    addr = 16'h0080;
    size = 16'd2;
    port = 4'd12;
    #1;
    chk("busy_resend", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    send = 1'b0;
    wait_done(b_done, 40);
    repeat (4) @(posedge clk);
    #1;
    chk("resend_latency",    32'(done_cyc - s0),     32'd13);
    chk("resend_handshakes", 32'(hs_cnt - b_hs),     32'd4);
    chk("resend_done_count", 32'(done_cnt - b_done), 32'd1);
    chk("resend_queue",      32'(exp_q.size()),      32'd0);

    // Reset after the second of five words abandons the transfer.
    b_done = done_cnt;
    b_hs   = hs_cnt;
    do_send(16'h0050, 16'd5, 4'd6, 1'b1);
    n = 0;
    while (hs_cnt < b_hs + 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_handshakes", 32'(hs_cnt - b_hs), 32'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_busy",     32'(busy),     32'd0);
    chk("mid_rst_done",     32'(done),     32'd0);
    rst = 1'b0;
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_no_done",    32'(done_cnt - b_done), 32'd0);
    chk("mid_rst_handshakes", 32'(hs_cnt - b_hs),     32'd2);

    b_done = done_cnt;
    b_hs   = hs_cnt;
    do_send(16'h0051, 16'd1, 4'd4, 1'b1);
    wait_done(b_done, 20);
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_latency",    32'(done_cyc - send_cyc), 32'd4);
    chk("post_rst_handshakes", 32'(hs_cnt - b_hs),       32'd1);
    chk("post_rst_queue",      32'(exp_q.size()),        32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
